demux_1b_1to128: RTL and testbench

// - 1-bit to 128-way demultiplexer: routes scalar input in_ to output bit
//   out[sel]; every other output bit is driven 0.
// - Datapath leaf used wherever a single enable/valid bit must be steered
//   to one of 128 destinations.
// - Combinational by default; an optional output register stage is

---
 rtl/demux_1b_1to128.sv | 62 ++++++
 tb/tb_demux_1b_1to128.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1b_1to128.sv
// ============================================================================
// Module   : demux_1b_1to128
// Purpose  : Steers one input bit to out[sel] of 128 outputs; all other bits 0.
//            Optional output register enabled by DEMUX_1B_1TO128_OUT_REG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_1b_1to128 #(
  parameter int NSEL = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_,
  input  logic [NSEL-1:0]         sel,
  output logic [(1 << NSEL)-1:0]  out
);

  localparam int NOUT = 1 << NSEL;

  logic [NOUT-1:0] w_demux;

  // Binary tree: level k splits each node on sel[NSEL-1-k]; node 2j is the
  // sel-bit-0 child of parent j, so leaf j of the last level is out[j].
  for (genvar k = 0; k < NSEL; k++) begin : g_level
    logic [(2 << k)-1:0] w_nodes;

    if (k == 0) begin : g_root
      assign w_nodes = {in_ & sel[NSEL-1], in_ & ~sel[NSEL-1]};
    end else begin : g_inner
      for (genvar j = 0; j < (1 << k); j++) begin : g_node
        assign w_nodes[2*j]   = g_level[k-1].w_nodes[j] & ~sel[NSEL-1-k];
        assign w_nodes[2*j+1] = g_level[k-1].w_nodes[j] &  sel[NSEL-1-k];
      end
    end
  end

  assign w_demux = g_level[NSEL-1].w_nodes;

`ifdef DEMUX_1B_1TO128_OUT_REG_EN
  logic [NOUT-1:0] r_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_demux;
    end
  end

  assign out = r_out;
`else
  // Clock and reset only matter for the registered build.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ reset;

  assign out = w_demux;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_1b_1to128.sv
// Self-checking bench for demux_1b_1to128 against a bit-array reference model.
`default_nettype none

module tb_demux_1b_1to128;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_;
  logic [6:0]   sel;
  logic [127:0] out;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  demux_1b_1to128 dut (
    .clk   (clk),
    .reset (reset),
    .in_   (in_),
    .sel   (sel),
    .out   (out)
  );

  // Reference: an all-zero vector with the addressed position set to the data bit.
  function automatic logic [127:0] model(input logic b, input int s);
    logic [127:0] r;
    r = '0;
    r[s] = b;
    return r;
  endfunction

  task automatic apply(input logic b, input int s);
    in_ = b;
    sel = 7'(s);
`ifdef DEMUX_1B_1TO128_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #8;
`endif
  endtask

`ifdef DEMUX_1B_1TO128_OUT_REG_EN
  task automatic test_reset;
    reset = 1'b1;
    in_ = 1'b1;
    sel = 7'd3;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 128'h0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", out, 128'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 5);
    checks++;
    if (out !== 128'h20) begin
      errors++;
      $display("FAIL first_capture got=%h want=%h", out, 128'h20);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out !== 128'h0) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", out, 128'h0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
`else
  task automatic test_reset;
    reset = 1'b1;
    apply(1'b1, 9);
    checks++;
    if (out !== model(1'b1, 9)) begin
      errors++;
      $display("FAIL reset_no_effect got=%h want=%h", out, model(1'b1, 9));
    end
    reset = 1'b0;
    #8;
    checks++;
    if (out !== model(1'b1, 9)) begin
      errors++;
      $display("FAIL reset_release_no_effect got=%h want=%h", out, model(1'b1, 9));
    end
    apply(1'b0, 9);
    checks++;
    if (out !== 128'h0) begin
      errors++;
      $display("FAIL zero_after_reset got=%h want=%h", out, 128'h0);
    end
  endtask
`endif

  task automatic test_directed;
    int          sels [6] = '{0, 1, 2, 3, 15, 100};
    logic [127:0] want1;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, sels[i]);
      want1 = model(1'b1, sels[i]);
      checks++;
      if (out !== want1 || $countones(out) != 1) begin
        errors++;
        $display("FAIL directed_one sel=%0d got=%h want=%h", sels[i], out, want1);
      end
      apply(1'b0, sels[i]);
      checks++;
      if (out !== 128'h0) begin
        errors++;
        $display("FAIL directed_zero sel=%0d got=%h want=%h", sels[i], out, 128'h0);
      end
    end
    apply(1'b1, 0);
    checks++;
    if (out !== 128'h1) begin
      errors++;
      $display("FAIL literal_sel0 got=%h want=%h", out, 128'h1);
    end
    apply(1'b1, 3);
    checks++;
    if (out !== 128'h8) begin
      errors++;
      $display("FAIL literal_sel3 got=%h want=%h", out, 128'h8);
    end
  endtask

  task automatic test_top_boundary;
    logic [127:0] top;
    top = {1'b1, 127'b0};
    apply(1'b1, 127);
    checks++;
    if (out !== top) begin
      errors++;
      $display("FAIL sel127_one got=%h want=%h", out, top);
    end
    apply(1'b0, 127);
    checks++;
    if (out !== 128'h0) begin
      errors++;
      $display("FAIL sel127_zero got=%h want=%h", out, 128'h0);
    end
  endtask

  task automatic test_sweep;
    for (int s = 0; s < 128; s++) begin
      apply(1'b1, s);
      checks++;
      if (out !== model(1'b1, s)) begin
        errors++;
        $display("FAIL sweep sel=%0d got=%h want=%h", s, out, model(1'b1, s));
      end
    end
  endtask

  task automatic test_random;
    logic b;
    int   s;
    for (int n = 0; n < 20; n++) begin
      b = 1'($urandom_range(1, 0));
      s = int'($urandom_range(127, 0));
      apply(b, s);
      checks++;
      if (out !== model(b, s)) begin
        errors++;
        $display("FAIL random in=%0b sel=%0d got=%h want=%h", b, s, out, model(b, s));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    in_   = 1'b0;
    sel   = 7'd0;
    #2;
    test_reset();
    test_directed();
    test_top_boundary();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
